// File: rtl/clk_div_meter.sv
// clk_div_meter: one-shot period / high-time meter for a slow or divided clock.
// sig_in is synchronized, rising edges are detected, and the clk cycles between
// two consecutive rises (plus the cycles spent high) are captured. The result
// is held under a valid/ack handshake; a timeout bounds every measurement.
module clk_div_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Last value tmo_cnt may reach before the measurement is declared timed out.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_sync;
  logic                   sig_sync_d;
  logic                   rise;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_nxt;
  logic [CNT_W-1:0] period_nxt, high_nxt;
  logic             timeout_nxt, valid_nxt, busy_nxt;

  assign sig_sync = sync_q[SYNC_STAGES-1];
  assign rise     = sig_sync & ~sig_sync_d;

  // Synchronizer chain for the asynchronous input plus the edge-detect delay flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      sig_sync_d <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_sync_d <= sig_sync;
    end
  end

  // Next-state and next-result logic; abort on en=0 takes priority, and a
  // completing rise takes priority over the timeout in the same cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hcnt_nxt    = hcnt;
    tmo_nxt     = tmo_cnt;
    period_nxt  = period;
    high_nxt    = high_time;
    timeout_nxt = timeout;
    valid_nxt   = valid;
    case (state)
      IDLE: begin
        if (start && en) begin
          state_nxt = WAIT_EDGE;
          tmo_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT_EDGE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          period_nxt  = '0;
          high_nxt    = '0;
          timeout_nxt = 1'b1;
          valid_nxt   = 1'b1;
          state_nxt   = DONE;
        end else begin
          tmo_nxt = tmo_cnt + ONE;
          if (rise) begin
            cnt_nxt   = ONE;
            hcnt_nxt  = ONE;
            state_nxt = MEASURE;
          end else begin
            state_nxt = WAIT_EDGE;
          end
        end
      end
      MEASURE: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (rise) begin
          period_nxt  = cnt;
          high_nxt    = hcnt;
          timeout_nxt = 1'b0;
          valid_nxt   = 1'b1;
          state_nxt   = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          period_nxt  = '0;
          high_nxt    = '0;
          timeout_nxt = 1'b1;
          valid_nxt   = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt  = cnt + ONE;
          hcnt_nxt = hcnt + CNT_W'(sig_sync);
          tmo_nxt  = tmo_cnt + ONE;
        end
      end
      DONE: begin
        if (ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt == WAIT_EDGE) || (state_nxt == MEASURE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      tmo_cnt   <= '0;
      period    <= '0;
      high_time <= '0;
      timeout   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hcnt      <= hcnt_nxt;
      tmo_cnt   <= tmo_nxt;
      period    <= period_nxt;
      high_time <= high_nxt;
      timeout   <= timeout_nxt;
      valid     <= valid_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
